fb_write_sequencer: RTL
=======================

# fb_write_sequencer

Camera-side sequencer for the double-buffered frame buffer. Converts the synchronized camera pixel stream (RGB565 plus skin-mask bit) into buffer write addresses and write strobes. It issues the buffer-swap pulse only after a complete frame has been written and the VGA side is in vertical blanking, so the display never tears. Incomplete or overrunning frames are dropped and counted. It sits between the camera capture/skin-detect pipeline and the frame buffer's write port, in the single `clk` domain.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- ADDR_WIDTH, 19, write address width; H_ACTIVE*V_ACTIVE must be ≤ 2^ADDR_WIDTH

- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cam_sof  in  1  one-cycle start-of-frame pulse, precedes the first pixel
- cam_valid  in  1  pixel qualifier
- cam_rgb  in  16  RGB565 pixel
- cam_mask  in  1  skin-mask bit for the pixel
- vga_vblank  in  1  level, high while VGA is in vertical blanking
- write_addr  out  ADDR_WIDTH  frame buffer write address
- write_rgb  out  16  registered pixel data
- write_mask  out  1  registered mask bit
- write_enable  out  1  write strobe
- frame_done  out  1  one-cycle buffer-swap pulse
- busy  out  1  high when state ≠ IDLE
- frames_written  out  8  completed swaps, wraps modulo 256
- frames_dropped  out  8  dropped frames, wraps modulo 256

## Operation
- Let TOTAL = H_ACTIVE*V_ACTIVE. The internal pixel counter `pix_cnt` is ADDR_WIDTH bits wide.
- **IDLE**
  - cam_valid is ignored.
  - cam_sof → pix_cnt = 0, go to CAPTURE.
- **CAPTURE**
  - Accepted pixel (cam_valid=1, cam_sof=0):
    - register write_addr=pix_cnt, write_rgb=cam_rgb, write_mask=cam_mask, write_enable=1;
    - pix_cnt++.
  - If the accepted pixel is pixel TOTAL-1, go to WAIT_SWAP.
  - cam_sof with pix_cnt < TOTAL is a short frame:
    - frames_dropped++, pix_cnt = 0, remain in CAPTURE;
    - no write that cycle, because cam_sof has priority over cam_valid in the same cycle.
  - Gaps in cam_valid are allowed; the address does not advance during a gap.
- **WAIT_SWAP**
  - write_enable stays 0 and cam_valid is ignored.
  - vga_vblank=1 → frame_done=1 for one cycle, frames_written++, go to IDLE.
  - cam_sof while waiting is an overrun: frames_dropped++ and remain in WAIT_SWAP. The overrunning frame is discarded entirely, because the completed frame is not overwritten. After the swap, capture resumes at the next cam_sof.
  - If cam_sof and vga_vblank=1 arrive in the same cycle, the swap wins: frame_done fires and that sof is still counted as dropped.
- write_enable and frame_done are never high in the same cycle.
- Counter behaviour:
  - frames_written and frames_dropped wrap 255 → 0.
  - pix_cnt never exceeds TOTAL-1 as an address.

## Timing
- Reset value of every output is 0, and the state is IDLE. Reset mid-CAPTURE or mid-WAIT_SWAP abandons the frame with no frame_done and no dropped-count increment.
- Write latency: a pixel accepted at cycle N appears on write_enable, write_addr and write_rgb during cycle N+1.
- The state enters WAIT_SWAP visible in cycle N+1, where N is the cycle of the last pixel. vga_vblank is sampled from cycle N+1 onward.
- frame_done is earliest at N+2, always at least one cycle after the final write strobe. It then follows one cycle after the first cycle in which vga_vblank=1 is sampled.
- A cam_sof arriving at cycle M, or on the cycle after returning to IDLE, starts a capture. The first pixel is accepted at M+1 at the earliest.
- busy rises the cycle after the accepted cam_sof and falls in the cycle after frame_done.

## Test plan
Use H_ACTIVE=8, V_ACTIVE=4 (TOTAL=32).
- **Full frame, vblank held high:** sof, then 32 back-to-back pixels with cam_rgb=index → exactly 32 write strobes at addr 0..31 with matching data. frame_done arrives 2 cycles after the last pixel; frames_written=1.
- **Vblank delayed:** vblank held low for 10 cycles after the last pixel, then raised → no frame_done while low. frame_done comes exactly 1 cycle after vblank rises, with no write strobes in between.
- **Short frame:** sof, 20 pixels, then sof plus a full 32-pixel frame → frames_dropped=1. The second frame's addresses restart at 0; frames_written=1 after the swap.
- **Overrun:** vblank low at frame end, sof plus 32 pixels arrive, then vblank high → frames_dropped=1 and zero writes from the overrun frame. One frame_done; the next sof captures normally.
- **Valid gaps plus same-cycle sof/valid:** random cam_valid gaps → contiguous addresses 0..31. A pixel presented together with sof is not written.
- **Reset mid-CAPTURE at pixel 15:** all outputs 0 and busy=0. A following full frame writes addr 0..31; both counters stay at 0 until its swap.

Source files
------------

// File: rtl/fb_write_sequencer.sv
// Camera-side write sequencer for the double-buffered frame buffer: turns the pixel
// stream into buffer writes and issues the swap pulse only in VGA vertical blanking.
module fb_write_sequencer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cam_sof,
  input  logic                  cam_valid,
  input  logic [15:0]           cam_rgb,
  input  logic                  cam_mask,
  input  logic                  vga_vblank,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [15:0]           write_rgb,
  output logic                  write_mask,
  output logic                  write_enable,
  output logic                  frame_done,
  output logic                  busy,
  output logic [7:0]            frames_written,
  output logic [7:0]            frames_dropped
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_SWAP} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pix_cnt;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [15:0]           r_write_rgb;
  logic                  r_write_mask;
  logic                  r_write_enable;
  logic                  r_frame_done;
  logic                  r_busy;
  logic [7:0]            r_frames_written;
  logic [7:0]            r_frames_dropped;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_pix_cnt        <= '0;
      r_write_addr     <= '0;
      r_write_rgb      <= '0;
      r_write_mask     <= 1'b0;
      r_write_enable   <= 1'b0;
      r_frame_done     <= 1'b0;
      r_busy           <= 1'b0;
      r_frames_written <= '0;
      r_frames_dropped <= '0;
    end else begin
      r_write_enable <= 1'b0;
      r_frame_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= cam_sof;
          if (cam_sof) begin
            r_pix_cnt <= '0;
            r_state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_busy <= 1'b1;
          // A new sof inside a frame means the previous one came up short.
          if (cam_sof) begin
            r_frames_dropped <= r_frames_dropped + 8'd1;
            r_pix_cnt        <= '0;
          end else if (cam_valid) begin
            r_write_addr   <= r_pix_cnt;
            r_write_rgb    <= cam_rgb;
            r_write_mask   <= cam_mask;
            r_write_enable <= 1'b1;
            if (r_pix_cnt == LAST_PIX) begin
              r_state <= WAIT_SWAP;
            end else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
            end
          end
        end
        WAIT_SWAP: begin
          // busy stays high through the frame_done cycle and drops one cycle later.
          r_busy <= 1'b1;
          if (cam_sof) begin
            r_frames_dropped <= r_frames_dropped + 8'd1;
          end
          if (vga_vblank) begin
            r_frame_done     <= 1'b1;
            r_frames_written <= r_frames_written + 8'd1;
            r_state          <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign write_addr     = r_write_addr;
  assign write_rgb      = r_write_rgb;
  assign write_mask     = r_write_mask;
  assign write_enable   = r_write_enable;
  assign frame_done     = r_frame_done;
  assign busy           = r_busy;
  assign frames_written = r_frames_written;
  assign frames_dropped = r_frames_dropped;

endmodule
